// File: rtl/lfsr_pkg.sv
// lfsr_pkg: opcodes and engine states shared by the LFSR PRPG core.
package lfsr_pkg;
  typedef enum logic [3:0] {
    NOP       = 4'd0,
    CFG_TAP   = 4'd1,
    INIT_L    = 4'd2,
    RUN       = 4'd3,
    STORE     = 4'd4,
    LOAD      = 4'd5,
    INIT_ADDR = 4'd6,
    ADD_ADDR  = 4'd7,
    STORE_HD  = 4'd9,
    CLR_STATS = 4'd10,
    HALT      = 4'd15
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one Galois LFSR step plus popcount of the bits it flips.
module lfsr_step #(
  parameter int WIDTH = 8,
  parameter int HD_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] q_next,
  output logic [HD_W-1:0]  hd
);
  always_comb begin
    q_next = {q[WIDTH-2:0], q[WIDTH-1]} ^ (tap & {{(WIDTH-1){q[WIDTH-1]}}, 1'b0});
    hd = '0;
    for (int i = 0; i < WIDTH; i++) hd = hd + HD_W'(q[i] ^ q_next[i]);
  end
endmodule

// File: rtl/lfsr_prpg_core.sv
// lfsr_prpg_core: command-driven Galois LFSR engine with pattern memory and step statistics.
module lfsr_prpg_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CYC_W = 8,
  parameter int SUM_W = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAP_DEFAULT = WIDTH'(8'h1C),
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int HD_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_arg,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_next,
  output logic [HD_W-1:0]   hd_last,
  output logic [SUM_W-1:0]  hd_sum,
  output logic [7:0]        run_count,
  output logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              halted
);
  state_e state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, tap_q, tap_d, mem_wdata, step_next;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HD_W-1:0] hd_last_q, hd_last_d, step_hd;
  logic [SUM_W-1:0] hd_sum_q, hd_sum_d;
  logic [SUM_W:0] sum_add;
  logic [7:0] run_count_q, run_count_d;
  logic done_q, done_d, mem_we;
  logic [WIDTH-1:0] mem_q [DEPTH];
  lfsr_step #(.WIDTH(WIDTH), .HD_W(HD_W)) u_step (
    .q(q_q), .tap(tap_q), .q_next(step_next), .hd(step_hd)
  );
  // Extra carry bit detects overflow for the saturating accumulator.
  assign sum_add = {1'b0, hd_sum_q} + (SUM_W + 1)'(step_hd);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    q_d = q_q;
    tap_d = tap_q;
    addr_d = addr_q;
    hd_last_d = hd_last_q;
    hd_sum_d = hd_sum_q;
    run_count_d = run_count_q;
    done_d = 1'b0;
    mem_we = 1'b0;
    mem_wdata = q_q;
    if (state_q == ST_RUN) begin
      q_d = step_next;
      hd_last_d = step_hd;
      hd_sum_d = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      cnt_d = cnt_q - CYC_W'(1);
      if (cnt_q == CYC_W'(1)) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
      end
    end else if (cmd_valid && cmd_ready) begin
      case (op_e'(cmd_op))
        CFG_TAP:   tap_d = cmd_arg;
        INIT_L:    q_d = cmd_arg;
        INIT_ADDR: addr_d = ADDR_W'(cmd_arg);
        ADD_ADDR:  addr_d = addr_q + ADDR_W'(cmd_arg);
        STORE:     mem_we = 1'b1;
        LOAD:      q_d = mem_q[addr_q];
        STORE_HD: begin
          mem_we = 1'b1;
          mem_wdata = WIDTH'(hd_sum_q);
        end
        CLR_STATS: begin
          hd_sum_d = '0;
          hd_last_d = '0;
          run_count_d = '0;
        end
        HALT:      state_d = ST_HALT;
        RUN: begin
          run_count_d = run_count_q + 8'd1;
          cnt_d = CYC_W'(cmd_arg);
          if (cnt_d == '0) done_d = 1'b1;
          else state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      q_q <= SEED;
      tap_q <= TAP_DEFAULT;
      addr_q <= '0;
      hd_last_q <= '0;
      hd_sum_q <= '0;
      run_count_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      tap_q <= tap_d;
      addr_q <= addr_d;
      hd_last_q <= hd_last_d;
      hd_sum_q <= hd_sum_d;
      run_count_q <= run_count_d;
      done_q <= done_d;
    end
  end
  // Pattern memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= mem_wdata;
  end
  assign cmd_ready = state_q == ST_IDLE;
  assign q = q_q;
  assign q_next = step_next;
  assign hd_last = hd_last_q;
  assign hd_sum = hd_sum_q;
  assign run_count = run_count_q;
  assign addr = addr_q;
  assign mem_rdata = mem_q[addr_q];
  assign busy = state_q == ST_RUN;
  assign done = done_q;
  assign halted = state_q == ST_HALT;
endmodule
